// File: rtl/instr_interface_packer_if.sv
// Bundles the host beat handshake and the packed-instruction delivery signals
// of the instruction packer.
interface instr_interface_packer_if #(
    parameter int IN_WIDTH      = 16,
    parameter int INSTR_WIDTH   = 64,
    parameter int ERR_CNT_WIDTH = 8
);
    logic [IN_WIDTH-1:0]      host_data;
    logic                     host_valid;
    logic                     host_sof;
    logic                     host_ready;
    logic                     buffer_full;
    logic [INSTR_WIDTH-1:0]   instr_out;
    logic                     instr_valid;
    logic [ERR_CNT_WIDTH-1:0] frame_err_cnt;

    modport master (
        output host_data, host_valid, host_sof, buffer_full,
        input  host_ready, instr_out, instr_valid, frame_err_cnt
    );

    modport slave (
        input  host_data, host_valid, host_sof, buffer_full,
        output host_ready, instr_out, instr_valid, frame_err_cnt
    );
endinterface

// File: rtl/instr_interface_packer.sv
// Packs IN_WIDTH host beats into INSTR_WIDTH instructions with start-of-frame
// checking, holding a finished word until the downstream buffer has room.
module instr_interface_packer #(
    parameter int IN_WIDTH      = 16,
    parameter int INSTR_WIDTH   = 64,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                   external_clk,
    input  logic                   rst,
    instr_interface_packer_if.slave bus
);
    localparam int BEATS = INSTR_WIDTH / IN_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    if (INSTR_WIDTH % IN_WIDTH != 0) begin : g_width_check
        $error("IN_WIDTH must divide INSTR_WIDTH");
    end

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       beat_idx;
    logic [INSTR_WIDTH-1:0] word_p0;

    logic             accept;
    logic             sof_err;
    logic             missing_sof;
    logic             take_beat;
    logic [IDX_W-1:0] place_idx;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign bus.host_ready = (state == COLLECT) && !rst;
    assign accept         = bus.host_valid && bus.host_ready;
    assign sof_err        = accept && bus.host_sof && (beat_idx != '0);
    assign missing_sof    = accept && !bus.host_sof && (beat_idx == '0);
    assign take_beat      = accept && !missing_sof;
    // A misplaced sof restarts the frame, so its beat lands in the LSBs.
    assign place_idx      = sof_err ? '0 : beat_idx;

    // Stage p0: beat assembly (data only, no reset)
    always_ff @(posedge external_clk) begin
        if (take_beat) begin
            word_p0[place_idx*IN_WIDTH +: IN_WIDTH] <= bus.host_data;
        end
    end

    // Control FSM and delivery registers
    always_ff @(posedge external_clk) begin
        if (rst) begin
            state             <= COLLECT;
            beat_idx          <= '0;
            bus.instr_out     <= '0;
            bus.instr_valid   <= 1'b0;
            bus.frame_err_cnt <= '0;
        end else begin
            bus.instr_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (missing_sof) begin
                            bus.frame_err_cnt <= sat_inc(bus.frame_err_cnt);
                        end else if (sof_err) begin
                            bus.frame_err_cnt <= sat_inc(bus.frame_err_cnt);
                            beat_idx          <= IDX_W'(1);
                        end else if (beat_idx == LAST_IDX) begin
                            beat_idx <= '0;
                            state    <= HOLD;
                        end else begin
                            beat_idx <= beat_idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.buffer_full) begin
                        bus.instr_out   <= word_p0;
                        bus.instr_valid <= 1'b1;
                        beat_idx        <= '0;
                        state           <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule
